dromajo_ram_arb: RTL and testbench
==================================

DROMAJO_RAM_ARB -- requirements
Module: dromajo_ram_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the RAM word-address width.
REQ-002 The block SHALL have parameter OUT_REGS, default 0, giving the RAM output register count; legal values are 0 and 1.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 Clk_CI  input  1  clock; all state updates on its rising edge.
REQ-005 Rst_RI  input  1  synchronous active-high reset.
REQ-006 Req_SI  input  2  per-port access request; bit p belongs to port p.
REQ-007 We_SI  input  2  per-port write (1) or read (0).
REQ-008 BEn_SI  input  16  per-port byte enables; port p at [8p+:8].
REQ-009 Addr_DI  input  2*ADDR_WIDTH  per-port word address; port p at [p*ADDR_WIDTH+:ADDR_WIDTH].
REQ-010 WrData_DI  input  128  per-port write data; port p at [64p+:64].
REQ-011 Gnt_SO  output  2  per-port grant, same cycle as the accepted request.
REQ-012 RValid_SO  output  2  per-port read-data valid, one-cycle pulse.
REQ-013 RdData_DO  output  128  per-port read data; port p at [64p+:64].
REQ-014 CSel_SO, WrEn_SO  output  1 each  RAM chip select and write enable.
REQ-015 BEn_SO  output  8; Addr_DO  output  ADDR_WIDTH; WrData_DO  output  64  RAM byte enables, address and write data.
REQ-016 RdData_DI  input  64  RAM read data.

Function
REQ-017 At most one Gnt_SO bit SHALL be high per cycle; a port's request SHALL be accepted exactly in the cycle its Gnt_SO bit is high.
REQ-018 Grant SHALL be combinational from Req_SI and the LastGnt register: one requester gets the grant; with two requesters, the port other than LastGnt gets it.
REQ-019 LastGnt SHALL update to the granted port index on every grant and hold otherwise.
REQ-020 While either port requests continuously, neither port SHALL wait more than 1 cycle for a grant.
REQ-021 On grant, CSel_SO SHALL be 1, and WrEn_SO, BEn_SO, Addr_DO and WrData_DO SHALL equal the granted port's fields in the same cycle.
REQ-022 With no grant, CSel_SO, WrEn_SO and BEn_SO SHALL be 0, and Addr_DO and WrData_DO SHALL be 0.
REQ-023 A requester SHALL hold Req, We, BEn, Addr and WrData stable until granted; the block SHALL NOT check this.
REQ-024 Each granted read SHALL push (valid, port) into a shift pipeline of depth 1+OUT_REGS.
REQ-025 The pipeline output SHALL pulse RValid_SO[port] exactly 1+OUT_REGS cycles after the grant cycle.
REQ-026 While RValid_SO[p] is high, RdData_DO[p] SHALL equal RdData_DI; otherwise RdData_DO[p] SHALL be 0.
REQ-027 Granted writes SHALL NOT enter the pipeline and SHALL produce no RValid_SO.
REQ-028 Back-to-back reads, from the same or alternating ports, SHALL be accepted every cycle; responses SHALL return in grant order, one per cycle.
REQ-029 A write granted in cycle N followed by a read of the same address granted in cycle N+1 SHALL return the written data, because the RAM is write-before-read across cycles.

Reset
REQ-030 While Rst_RI is 1: Gnt_SO, RValid_SO, CSel_SO, WrEn_SO, BEn_SO, Addr_DO, WrData_DO and RdData_DO SHALL be 0; LastGnt SHALL reset to 1, so port 0 wins the first conflict; all pipeline valid bits SHALL clear.
REQ-031 Reads in flight when reset asserts SHALL be discarded; no RValid_SO SHALL assert for them after reset deasserts.
REQ-032 After reset deasserts, the first grant SHALL be possible in the first cycle with Rst_RI at 0.

Verification
REQ-033 Port 0 writes addr 5, data 64'hDEAD_BEEF_0123_4567, BEn 8'hFF; port 0 then reads addr 5 -> RValid_SO[0] pulses 1+OUT_REGS cycles after the read grant, with RdData_DO[0]=64'hDEAD_BEEF_0123_4567.
REQ-034 Both ports request reads every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1, and RValid pulses alternate in the same order.
REQ-035 Port 1 writes addr 3, data 64'h0, BEn 8'hFF, then writes addr 3, data 64'hFFFF_FFFF_FFFF_FFFF, BEn 8'h0F; a read of addr 3 -> 64'h0000_0000_FFFF_FFFF.
REQ-036 Only port 1 requests for 4 cycles -> Gnt_SO=2'b10 every cycle, with no idle gaps.
REQ-037 Read grant in cycle N, Rst_RI=1 in cycle N+1 -> RValid_SO stays 0 through 4 cycles after reset release; the next conflict grants port 0.
REQ-038 Both OUT_REGS=0 and OUT_REGS=1 builds -> read latency is exactly 1 and 2 cycles respectively.

Source files
------------

// File: rtl/dromajo_ram_arb.sv
// -----------------------------------------------------------------------------
// dromajo_ram_arb
// Two-port round-robin arbiter in front of a single-port, byte-enabled RAM.
// The winning port's request is forwarded to the RAM in the grant cycle. Read
// grants are tracked through a short valid/port pipeline so each read response
// is routed back to the port that issued it. The pipeline depth matches the RAM
// read latency, which is 1 + OUT_REGS cycles.
//
// Parameters
//   ADDR_WIDTH  RAM word-address width
//   OUT_REGS    RAM output register count (0 or 1)
//
// Ports
//   Clk_CI      clock, rising edge
//   Rst_RI      synchronous active-high reset
//   Req_SI      per-port request           (port p at bit p)
//   We_SI       per-port write(1)/read(0)  (port p at bit p)
//   BEn_SI      per-port byte enables      (port p at [8p+:8])
//   Addr_DI     per-port word address      (port p at [p*ADDR_WIDTH+:ADDR_WIDTH])
//   WrData_DI   per-port write data        (port p at [64p+:64])
//   Gnt_SO      per-port grant, same cycle as the accepted request
//   RValid_SO   per-port read-data valid pulse
//   RdData_DO   per-port read data, zero when not valid
//   CSel_SO, WrEn_SO, BEn_SO, Addr_DO, WrData_DO   RAM request side
//   RdData_DI   RAM read data
// -----------------------------------------------------------------------------
module dromajo_ram_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_REGS   = 0
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    input  logic [1:0]              Req_SI,
    input  logic [1:0]              We_SI,
    input  logic [15:0]             BEn_SI,
    input  logic [2*ADDR_WIDTH-1:0] Addr_DI,
    input  logic [127:0]            WrData_DI,
    output logic [1:0]              Gnt_SO,
    output logic [1:0]              RValid_SO,
    output logic [127:0]            RdData_DO,
    output logic                    CSel_SO,
    output logic                    WrEn_SO,
    output logic [7:0]              BEn_SO,
    output logic [ADDR_WIDTH-1:0]   Addr_DO,
    output logic [63:0]             WrData_DO,
    input  logic [63:0]             RdData_DI
);

    localparam int PIPE_DEPTH = 1 + OUT_REGS;

    logic                  last_gnt_r;   // index of the most recently granted port
    logic [1:0]            gnt_s;
    logic                  gnt_idx_s;
    logic                  rd_push_s;
    logic [PIPE_DEPTH-1:0] pipe_vld_r;
    logic [PIPE_DEPTH-1:0] pipe_port_r;
    logic                  rvld_s;
    logic                  rport_s;

    // Grant selection: a lone requester wins; on conflict the port that was not granted last wins.
    always_comb begin
        gnt_s = 2'b00;
        if (Rst_RI) begin
            gnt_s = 2'b00;
        end else begin
            case (Req_SI)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = last_gnt_r ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end
    end

    assign gnt_idx_s = gnt_s[1];
    assign rd_push_s = (gnt_s != 2'b00) && !(gnt_idx_s ? We_SI[1] : We_SI[0]);

    // RAM request mux: forward the granted port's fields, drive all zeros when idle.
    always_comb begin
        CSel_SO   = 1'b0;
        WrEn_SO   = 1'b0;
        BEn_SO    = 8'h00;
        Addr_DO   = {ADDR_WIDTH{1'b0}};
        WrData_DO = 64'h0;
        if (gnt_s != 2'b00) begin
            CSel_SO   = 1'b1;
            WrEn_SO   = gnt_idx_s ? We_SI[1] : We_SI[0];
            BEn_SO    = gnt_idx_s ? BEn_SI[15:8] : BEn_SI[7:0];
            Addr_DO   = gnt_idx_s ? Addr_DI[2*ADDR_WIDTH-1:ADDR_WIDTH] : Addr_DI[ADDR_WIDTH-1:0];
            WrData_DO = gnt_idx_s ? WrData_DI[127:64] : WrData_DI[63:0];
        end else begin
            CSel_SO   = 1'b0;
        end
    end

    // Round-robin history: reset to port 1 so port 0 wins the first conflict.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            last_gnt_r <= 1'b1;
        end else if (gnt_s != 2'b00) begin
            last_gnt_r <= gnt_idx_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    // Read-tracking pipeline, aligned with the RAM read latency; reset drops in-flight reads.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            pipe_vld_r  <= {PIPE_DEPTH{1'b0}};
            pipe_port_r <= {PIPE_DEPTH{1'b0}};
        end else begin
            pipe_vld_r[0]  <= rd_push_s;
            pipe_port_r[0] <= gnt_idx_s;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_port_r[i] <= pipe_port_r[i-1];
            end
        end
    end

    // The pipeline still holds its old contents during the first reset cycle, so mask it here.
    assign rvld_s  = pipe_vld_r[PIPE_DEPTH-1] & ~Rst_RI;
    assign rport_s = pipe_port_r[PIPE_DEPTH-1];

    assign Gnt_SO    = gnt_s;
    assign RValid_SO = {rvld_s & rport_s, rvld_s & ~rport_s};
    assign RdData_DO = {(RValid_SO[1] ? RdData_DI : 64'h0), (RValid_SO[0] ? RdData_DI : 64'h0)};

endmodule

// File: tb/tb_dromajo_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_dromajo_ram_arb
// Drives two arbiter instances (OUT_REGS = 0 and 1) with identical stimulus.
// Each instance has its own behavioural RAM. Expected grants and RAM request
// fields are computed from a small round-robin model. Read responses are
// predicted from a reference memory and queued per instance with their due
// cycle. They are popped and compared when the RValid pulse is due.
// -----------------------------------------------------------------------------
module tb_dromajo_ram_arb;

    localparam int AW = 10;

    typedef struct {
        int          due;
        int          port;
        logic [63:0] data;
    } sb_t;

    logic            clk;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [15:0]     ben;
    logic [2*AW-1:0] addr;
    logic [127:0]    wdata;

    logic [1:0]      gnt    [2];
    logic [1:0]      rvalid [2];
    logic [127:0]    rdo    [2];
    logic            csel   [2];
    logic            wren   [2];
    logic [7:0]      beno   [2];
    logic [AW-1:0]   addro  [2];
    logic [63:0]     wdo    [2];

    int              errors;
    int              checks;
    int              cyc;
    logic            lg_m;
    logic [1:0]      last_eg;
    logic [63:0]     ref_mem [0:(1<<AW)-1];
    sb_t             sb_q0 [$];
    sb_t             sb_q1 [$];

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] be);
        logic [63:0] res;
        res = old_w;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [63:0] mem [0:(1<<AW)-1];
        logic [63:0] rd1_r;
        logic [63:0] rd2_r;

        dromajo_ram_arb #(.ADDR_WIDTH(AW), .OUT_REGS(g)) u_dut (
            .Clk_CI    (clk),
            .Rst_RI    (rst),
            .Req_SI    (req),
            .We_SI     (we),
            .BEn_SI    (ben),
            .Addr_DI   (addr),
            .WrData_DI (wdata),
            .Gnt_SO    (gnt[g]),
            .RValid_SO (rvalid[g]),
            .RdData_DO (rdo[g]),
            .CSel_SO   (csel[g]),
            .WrEn_SO   (wren[g]),
            .BEn_SO    (beno[g]),
            .Addr_DO   (addro[g]),
            .WrData_DO (wdo[g]),
            .RdData_DI (g == 0 ? rd1_r : rd2_r)
        );

        // Behavioural RAM: write-before-read across cycles, optional output register.
        always @(posedge clk) begin
            if (csel[g] && wren[g]) mem[addro[g]] <= merge(mem[addro[g]], wdo[g], beno[g]);
            if (csel[g] && !wren[g]) rd1_r <= mem[addro[g]];
            rd2_r <= rd1_r;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [7:0] b,
                         input logic [AW-1:0] a, input logic [63:0] d);
        req[p]           = r;
        we[p]            = w;
        ben[p*8 +: 8]    = b;
        addr[p*AW +: AW] = a;
        wdata[p*64 +: 64] = d;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 8'h00, 10'd0, 64'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 10'd0, 64'h0);
    endtask

    // One clock cycle: check this cycle's outputs of both instances, update the model, advance.
    task automatic step();
        logic [1:0]    eg;
        logic [1:0]    ev;
        logic [127:0]  ed;
        logic          hit;
        int            p;
        logic [AW-1:0] a;
        sb_t           e;
        #1;
        eg = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   eg = 2'b01;
                2'b10:   eg = 2'b10;
                2'b11:   eg = lg_m ? 2'b01 : 2'b10;
                default: eg = 2'b00;
            endcase
        end
        p = eg[1] ? 1 : 0;
        a = addr[p*AW +: AW];
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("gnt[%0d]", g), 128'(gnt[g]), 128'(eg));
            chk($sformatf("csel[%0d]", g), 128'(csel[g]), 128'(eg != 2'b00));
            if (eg != 2'b00) begin
                chk($sformatf("wren[%0d]", g), 128'(wren[g]), 128'(we[p]));
                chk($sformatf("ben[%0d]", g), 128'(beno[g]), 128'(ben[p*8 +: 8]));
                chk($sformatf("addr[%0d]", g), 128'(addro[g]), 128'(a));
                chk($sformatf("wdata[%0d]", g), 128'(wdo[g]), 128'(wdata[p*64 +: 64]));
            end else begin
                chk($sformatf("idle_req[%0d]", g), {wren[g], beno[g], addro[g], wdo[g]}, 128'd0);
            end
            ev  = 2'b00;
            ed  = 128'd0;
            hit = 1'b0;
            if (!rst) begin
                if (g == 0) begin
                    while (sb_q0.size() > 0 && sb_q0[0].due < cyc) void'(sb_q0.pop_front());
                    if (sb_q0.size() > 0 && sb_q0[0].due == cyc) begin e = sb_q0.pop_front(); hit = 1'b1; end
                end else begin
                    while (sb_q1.size() > 0 && sb_q1[0].due < cyc) void'(sb_q1.pop_front());
                    if (sb_q1.size() > 0 && sb_q1[0].due == cyc) begin e = sb_q1.pop_front(); hit = 1'b1; end
                end
                if (hit) begin
                    ev = (e.port == 1) ? 2'b10 : 2'b01;
                    ed = (e.port == 1) ? {e.data, 64'h0} : {64'h0, e.data};
                end
            end
            chk($sformatf("rvalid[%0d]", g), 128'(rvalid[g]), 128'(ev));
            chk($sformatf("rdata[%0d]", g), rdo[g], ed);
        end
        if (rst) begin
            sb_q0.delete();
            sb_q1.delete();
            lg_m = 1'b1;
        end else if (eg != 2'b00) begin
            lg_m = eg[1];
            if (we[p]) begin
                ref_mem[a] = merge(ref_mem[a], wdata[p*64 +: 64], ben[p*8 +: 8]);
            end else begin
                e.port = p;
                e.data = ref_mem[a];
                e.due  = cyc + 1;
                sb_q0.push_back(e);
                e.due  = cyc + 2;
                sb_q1.push_back(e);
            end
        end
        last_eg = eg;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req = 2'b11;  // requests during reset must not be granted
        we  = 2'b00;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        lg_m    = 1'b1;
        last_eg = 2'b00;
        rst     = 1'b1;
        idle();
        @(negedge clk);
        do_reset(2);

        // Preload addresses 0..15 through port 0, one write per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b1, 8'hFF, AW'(i), {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h0101_0101});
            step();
        end
        idle();

        // Port 0 write then read of address 5.
        drive(0, 1'b1, 1'b1, 8'hFF, 10'd5, 64'hDEAD_BEEF_0123_4567);
        step();
        drive(0, 1'b1, 1'b0, 8'hFF, 10'd5, 64'h0);
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("ref_addr5", 128'(ref_mem[5]), 128'(64'hDEAD_BEEF_0123_4567));

        // Port 1 partial-byte write merge on address 3.
        drive(1, 1'b1, 1'b1, 8'hFF, 10'd3, 64'h0);
        step();
        drive(1, 1'b1, 1'b1, 8'h0F, 10'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        drive(1, 1'b1, 1'b0, 8'h00, 10'd3, 64'h0);
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("ref_addr3", 128'(ref_mem[3]), 128'(64'h0000_0000_FFFF_FFFF));

        // Both ports read every cycle for 6 cycles right after reset: grants alternate from port 0.
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, 8'h00, AW'(i), 64'h0);
            drive(1, 1'b1, 1'b0, 8'h00, AW'(i + 8), 64'h0);
            step();
            chk("alt_gnt", 128'(last_eg), (i % 2 == 0) ? 128'd1 : 128'd2);
        end
        idle();
        for (int i = 0; i < 3; i++) step();

        // Only port 1 requests for 4 cycles: granted every cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, i[0], 8'hFF, AW'(i + 10), 64'h1111_0000 + 64'(i));
            step();
            chk("solo_p1", 128'(last_eg), 128'd2);
        end
        idle();
        for (int i = 0; i < 3; i++) step();

        // Read in flight when reset asserts is discarded; next conflict goes to port 0.
        drive(1, 1'b1, 1'b0, 8'h00, 10'd7, 64'h0);
        step();
        do_reset(1);
        for (int i = 0; i < 4; i++) step();
        drive(0, 1'b1, 1'b0, 8'h00, 10'd1, 64'h0);
        drive(1, 1'b1, 1'b0, 8'h00, 10'd2, 64'h0);
        step();
        chk("post_rst_conflict", 128'(last_eg), 128'd1);
        idle();
        for (int i = 0; i < 3; i++) step();

        // Random traffic; a requester keeps its fields until it is granted.
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || last_eg[p]) begin
                    drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                          AW'($urandom_range(0, 15)), {$urandom, $urandom});
                end
            end
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("drain", 128'(sb_q0.size() + sb_q1.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
